// File: rtl/conv_weight_load_controller.sv
// Weight-load sequencer for the conv layer: streams one 3x3 kernel plus bias
// from the weight ROM into the kernel array under a cmd/ack handshake.
module conv_weight_load_controller #(
  parameter int WIDTH            = 32,
  parameter int KERNEL_SIZE      = 3,
  parameter int TOTAL_WEIGHT     = 4,
  parameter int WORDS_PER_KERNEL = 10,
  parameter int ADDR_WIDTH       = 6,
  parameter int ROM_DEPTH        = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            weight_cmd,
  output logic [1:0]            weight_ack,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic                  kernel_wr_en,
  output logic [3:0]            kernel_wr_idx,
  output logic [WIDTH-1:0]      kernel_data,
  output logic [1:0]            kernel_sel
);

  localparam logic [1:0] CMD_LOAD_START = 2'd1;
  localparam logic [1:0] CMD_RESET_IDX  = 2'd2;
  localparam logic [1:0] ACK_IDLE       = 2'd0;
  localparam logic [1:0] ACK_LOAD_FIN   = 2'd1;
  localparam logic [1:0] ACK_BUSY       = 2'd2;

  // The bias occupies the slot right after the KERNEL_SIZE^2 weights.
  localparam logic [3:0]            LAST_WORD     = 4'(KERNEL_SIZE * KERNEL_SIZE);
  localparam logic [1:0]            LAST_SEL      = 2'(TOTAL_WEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] KERNEL_STRIDE = ADDR_WIDTH'(WORDS_PER_KERNEL);

  if (ROM_DEPTH < TOTAL_WEIGHT * WORDS_PER_KERNEL) begin : g_rom_too_small
    $error("ROM_DEPTH cannot hold TOTAL_WEIGHT kernels");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t                  state_r;
  logic [3:0]              word_cnt_r;
  logic [3:0]              rd_idx_r;
  logic [1:0]              kernel_sel_r;
  logic [1:0]              ack_r;
  logic                    rom_en_r;
  logic [ADDR_WIDTH-1:0]   rom_addr_r;
  logic                    kernel_wr_en_r;
  logic [3:0]              kernel_wr_idx_r;
  logic [WIDTH-1:0]        kernel_data_r;
  logic [ADDR_WIDTH-1:0]   fetch_addr_s;

  assign fetch_addr_s = (ADDR_WIDTH'(kernel_sel_r) * KERNEL_STRIDE) + ADDR_WIDTH'(word_cnt_r);

  // Load sequencer: command decode, ROM read issue, kernel index and ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      word_cnt_r   <= 4'd0;
      rd_idx_r     <= 4'd0;
      kernel_sel_r <= 2'd0;
      ack_r        <= ACK_IDLE;
      rom_en_r     <= 1'b0;
      rom_addr_r   <= '0;
    end else if (!enable) begin
      // Frozen: no new reads; a pending LOAD_FIN pulse must not stretch.
      rom_en_r <= 1'b0;
      ack_r    <= (ack_r == ACK_LOAD_FIN) ? ACK_IDLE : ack_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rom_en_r <= 1'b0;
          case (weight_cmd)
            CMD_LOAD_START: begin
              state_r    <= ST_FETCH;
              word_cnt_r <= 4'd0;
              ack_r      <= ACK_BUSY;
            end
            CMD_RESET_IDX: begin
              kernel_sel_r <= 2'd0;
              ack_r        <= ACK_IDLE;
            end
            default: ack_r <= ACK_IDLE;
          endcase
        end
        ST_FETCH: begin
          rom_en_r   <= 1'b1;
          rom_addr_r <= fetch_addr_s;
          rd_idx_r   <= word_cnt_r;
          ack_r      <= ACK_BUSY;
          if (word_cnt_r == LAST_WORD) begin
            state_r    <= ST_DRAIN;
            word_cnt_r <= 4'd0;
          end else begin
            word_cnt_r <= word_cnt_r + 4'd1;
          end
        end
        ST_DRAIN: begin
          rom_en_r <= 1'b0;
          ack_r    <= ACK_BUSY;
          state_r  <= ST_FIN;
        end
        ST_FIN: begin
          rom_en_r     <= 1'b0;
          ack_r        <= ACK_LOAD_FIN;
          kernel_sel_r <= (kernel_sel_r == LAST_SEL) ? 2'd0 : kernel_sel_r + 2'd1;
          state_r      <= ST_IDLE;
        end
        default: begin
          rom_en_r <= 1'b0;
          ack_r    <= ACK_IDLE;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  // Write pipeline runs regardless of enable so an issued read is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kernel_wr_en_r  <= 1'b0;
      kernel_wr_idx_r <= 4'd0;
      kernel_data_r   <= '0;
    end else begin
      kernel_wr_en_r  <= rom_en_r;
      kernel_wr_idx_r <= rd_idx_r;
      kernel_data_r   <= rom_data;
    end
  end

  assign weight_ack    = ack_r;
  assign rom_en        = rom_en_r;
  assign rom_addr      = rom_addr_r;
  assign kernel_wr_en  = kernel_wr_en_r;
  assign kernel_wr_idx = kernel_wr_idx_r;
  assign kernel_data   = kernel_data_r;
  assign kernel_sel    = kernel_sel_r;

endmodule

// File: tb/tb_conv_weight_load_controller.sv
// Self-checking bench for conv_weight_load_controller: scoreboard of ROM reads
// and kernel writes, per-cycle timing checks, and an IDLE command table.
module tb_conv_weight_load_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  weight_cmd;
  logic [1:0]  weight_ack;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic        kernel_wr_en;
  logic [3:0]  kernel_wr_idx;
  logic [31:0] kernel_data;
  logic [1:0]  kernel_sel;

  always #5 clk = ~clk;

  conv_weight_load_controller dut (
    .clk(clk), .rst(rst), .enable(enable), .weight_cmd(weight_cmd),
    .weight_ack(weight_ack), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .kernel_wr_en(kernel_wr_en),
    .kernel_wr_idx(kernel_wr_idx), .kernel_data(kernel_data),
    .kernel_sel(kernel_sel)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    logic [1:0] cmd;
    logic       en;
    logic [1:0] ack;
    logic [1:0] sel;
  } vec_t;

  logic [5:0] addr_q[$];
  wr_exp_t    wr_q[$];
  int checks   = 0;
  int failures = 0;
  int model_sel = 0;

  // Distinct, address-dependent ROM contents.
  function automatic logic [31:0] rom_word(input logic [5:0] a);
    return {8'hA5, 2'b00, a, 8'h3C, 2'b00, ~a};
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expect(input int base);
    for (int i = 0; i < 10; i++) begin
      wr_exp_t e;
      e.idx  = 4'(i);
      e.data = rom_word(6'(base + i));
      addr_q.push_back(6'(base + i));
      wr_q.push_back(e);
    end
  endtask

  // Scoreboard: every ROM read and kernel write is matched against the model.
  always @(negedge clk) begin : monitor
    logic [5:0] a;
    wr_exp_t    e;
    if (rom_en) begin
      if (addr_q.size() == 0) check("rom_rd_unexpected", 32'(rom_en), 32'd0);
      else begin
        a = addr_q.pop_front();
        check("rom_addr", 32'(rom_addr), 32'(a));
      end
    end
    if (kernel_wr_en) begin
      if (wr_q.size() == 0) check("kernel_wr_unexpected", 32'(kernel_wr_en), 32'd0);
      else begin
        e = wr_q.pop_front();
        check("kernel_wr_idx", 32'(kernel_wr_idx), 32'(e.idx));
        check("kernel_data", kernel_data, e.data);
      end
    end
  end

  // One full load; optional enable stall and command injection during FETCH.
  task automatic run_load(input int stall_after, input int stall_len, input bit inject);
    int base;
    int fin_e;
    bit exp_en;
    base  = model_sel * 10;
    fin_e = -1;
    push_expect(base);
    weight_cmd = 2'd1;
    enable     = 1'b1;
    @(negedge clk);
    weight_cmd = 2'd0;
    check("ack_busy_start", 32'(weight_ack), 32'd2);
    for (int e = 1; e <= 40 && fin_e < 0; e++) begin
      enable = !(e > stall_after && e <= stall_after + stall_len);
      weight_cmd = inject ? ((e == 3) ? 2'd1 : ((e == 5) ? 2'd2 : 2'd0)) : 2'd0;
      @(negedge clk);
      exp_en = (e <= stall_after && e <= 10) ||
               (e > stall_after + stall_len && e <= 10 + stall_len);
      check("rom_en", 32'(rom_en), 32'(exp_en));
      if (weight_ack == 2'd1) fin_e = e;
      else check("ack_busy", 32'(weight_ack), 32'd2);
    end
    enable     = 1'b1;
    weight_cmd = 2'd0;
    check("fin_edge", 32'(fin_e), 32'(12 + stall_len));
    model_sel = (model_sel + 1) % 4;
    check("kernel_sel", 32'(kernel_sel), 32'(model_sel));
    check("rom_addr_hold", 32'(rom_addr), 32'(base + 9));
    check("rd_q_empty", 32'(addr_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    vec_t vt[7];
    int fin_cnt;
    vt[0] = '{cmd: 2'd3, en: 1'b1, ack: 2'd0, sel: 2'd3};
    vt[1] = '{cmd: 2'd0, en: 1'b1, ack: 2'd0, sel: 2'd3};
    vt[2] = '{cmd: 2'd2, en: 1'b0, ack: 2'd0, sel: 2'd3};
    vt[3] = '{cmd: 2'd3, en: 1'b0, ack: 2'd0, sel: 2'd3};
    vt[4] = '{cmd: 2'd1, en: 1'b0, ack: 2'd0, sel: 2'd3};
    vt[5] = '{cmd: 2'd2, en: 1'b1, ack: 2'd0, sel: 2'd0};
    vt[6] = '{cmd: 2'd3, en: 1'b1, ack: 2'd0, sel: 2'd0};

    rst = 1'b1; enable = 1'b0; weight_cmd = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(weight_ack), 32'd0);
    check("rst_rom_en", 32'(rom_en), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_wr_en", 32'(kernel_wr_en), 32'd0);
    check("rst_wr_idx", 32'(kernel_wr_idx), 32'd0);
    check("rst_data", kernel_data, 32'd0);
    check("rst_sel", 32'(kernel_sel), 32'd0);
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("idle_ack", 32'(weight_ack), 32'd0);

    // Five back-to-back loads: bases 0,10,20,30 then wrap to 0.
    for (int k = 0; k < 5; k++) run_load(10, 0, 1'b0);
    @(negedge clk);
    check("ack_one_cycle", 32'(weight_ack), 32'd0);

    // Three-cycle stall after the 4th read.
    run_load(4, 3, 1'b0);
    // Commands during FETCH must be ignored.
    run_load(10, 0, 1'b1);

    // LOAD_FIN must not stretch across a freeze.
    enable = 1'b0;
    @(negedge clk);
    check("fin_freeze_ack", 32'(weight_ack), 32'd0);
    check("fin_freeze_rom_en", 32'(rom_en), 32'd0);
    enable = 1'b1;

    for (int i = 0; i < 7; i++) begin
      weight_cmd = vt[i].cmd;
      enable     = vt[i].en;
      @(negedge clk);
      check("tbl_ack", 32'(weight_ack), 32'(vt[i].ack));
      check("tbl_sel", 32'(kernel_sel), 32'(vt[i].sel));
      check("tbl_rom_en", 32'(rom_en), 32'd0);
      check("tbl_wr_en", 32'(kernel_wr_en), 32'd0);
    end
    weight_cmd = 2'd0; enable = 1'b1;
    model_sel = 0;

    // Reset during the 6th read aborts the load without an ack.
    push_expect(0);
    weight_cmd = 2'd1;
    @(negedge clk);
    weight_cmd = 2'd0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ack", 32'(weight_ack), 32'd0);
    check("abort_rom_en", 32'(rom_en), 32'd0);
    check("abort_rom_addr", 32'(rom_addr), 32'd0);
    check("abort_wr_en", 32'(kernel_wr_en), 32'd0);
    check("abort_wr_idx", 32'(kernel_wr_idx), 32'd0);
    check("abort_data", kernel_data, 32'd0);
    check("abort_sel", 32'(kernel_sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    addr_q.delete();
    wr_q.delete();
    model_sel = 0;
    fin_cnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (weight_ack == 2'd1) fin_cnt++;
    end
    check("no_fin_after_abort", 32'(fin_cnt), 32'd0);
    run_load(10, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
